alu_control_seq: RTL and testbench

Parametrised next-generation ALU control for the RISC-V core. It decodes ALU_Op/funct fields into a 5-bit ALU control code covering full RV32I plus the M extension. It also sequences multi-cycle MUL/DIV/REM operations on the iterative shift-add/restoring datapath through counted step strobes. It sits between the decode stage and the execute datapath, with valid/ready handshakes on both sides.

---
 rtl/alu_control_seq_if.sv | 35 +++
 rtl/alu_control_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_control_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_seq_if.sv
// Decode-to-execute handshake bundle for the ALU control sequencer.
// slave = the sequencer, master = the decode/execute side driving it.
interface alu_control_seq_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             funct7_0;
  logic             div_zero;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       alu_ctrl;
  logic             illegal;
  logic             step_en;
  logic             step_first;
  logic             step_last;
  logic [CNT_W-1:0] step_cnt;
  logic             dz_bypass;

  modport slave (
    input  in_valid, alu_op, funct3, funct7_5, funct7_0, div_zero, out_ready,
    output in_ready, out_valid, alu_ctrl, illegal, step_en, step_first,
           step_last, step_cnt, dz_bypass
  );

  modport master (
    output in_valid, alu_op, funct3, funct7_5, funct7_0, div_zero, out_ready,
    input  in_ready, out_valid, alu_ctrl, illegal, step_en, step_first,
           step_last, step_cnt, dz_bypass
  );
endinterface

// File: rtl/alu_control_seq.sv
// RV32IM ALU control decoder with a step sequencer for the iterative MUL/DIV datapath.
// A completed op is "DONE" while it sits in IDLE with out_valid high.
module alu_control_seq #(
  parameter int  XLEN      = 32,
  parameter bit  MULDIV_EN = 1'b1,
  localparam int CNT_W     = $clog2(XLEN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  alu_control_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ITER = 2'b01;

  localparam logic [4:0] C_AND  = 5'b00000;
  localparam logic [4:0] C_OR   = 5'b00001;
  localparam logic [4:0] C_ADD  = 5'b00010;
  localparam logic [4:0] C_XOR  = 5'b00011;
  localparam logic [4:0] C_SLL  = 5'b00100;
  localparam logic [4:0] C_SRL  = 5'b00101;
  localparam logic [4:0] C_SUB  = 5'b00110;
  localparam logic [4:0] C_SLT  = 5'b00111;
  localparam logic [4:0] C_SLTU = 5'b01000;
  localparam logic [4:0] C_SRA  = 5'b01001;
  localparam logic [4:0] C_ILL  = 5'b11111;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(XLEN - 2);

  // Base integer op shared by R-type and I-type; funct7_5 only qualifies R-type outside shifts.
  function automatic logic [4:0] base_op(input logic [2:0] f3, input logic f75,
                                         input logic rtype);
    logic [4:0] code;
    code = C_ILL;
    case (f3)
      3'b000:  code = (rtype && f75) ? C_SUB : C_ADD;
      3'b101:  code = f75 ? C_SRA : C_SRL;
      3'b001:  code = C_SLL;
      3'b010:  code = C_SLT;
      3'b011:  code = C_SLTU;
      3'b100:  code = C_XOR;
      3'b110:  code = C_OR;
      3'b111:  code = C_AND;
      default: code = C_ILL;
    endcase
    if (rtype && f75 && (f3 != 3'b000) && (f3 != 3'b101)) begin
      code = C_ILL;
    end
    return code;
  endfunction

  function automatic logic [4:0] decode_op(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f75, input logic f70);
    logic [4:0] code;
    code = C_ILL;
    case (op)
      2'b00: code = C_ADD;
      2'b01: code = C_SUB;
      2'b10: begin
        if (f70) begin
          code = (f75 || !MULDIV_EN) ? C_ILL : {2'b10, f3};
        end else begin
          code = base_op(f3, f75, 1'b1);
        end
      end
      2'b11:   code = base_op(f3, f75, 1'b0);
      default: code = C_ILL;
    endcase
    return code;
  endfunction

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_r;
  logic [4:0]       alu_ctrl_r;
  logic             illegal_r;
  logic             dz_bypass_r;
  logic             step_en_r;
  logic             step_first_r;
  logic             step_last_r;

  logic [4:0] code_s;
  logic       in_ready_s;
  logic       accept_s;
  logic       is_mop_s;
  logic       dz_hit_s;
  logic       iter_s;

  // Decode and accept qualification for the op presented this cycle.
  always_comb begin
    code_s     = decode_op(bus.alu_op, bus.funct3, bus.funct7_5, bus.funct7_0);
    in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s && !flush;
    is_mop_s   = (code_s[4:3] == 2'b10);
    // Only DIV/DIVU/REM/REMU (10100..10111) short-circuit on a zero divisor.
    dz_hit_s   = is_mop_s && code_s[2] && bus.div_zero;
    iter_s     = is_mop_s && !dz_hit_s;
  end

  // Control FSM, output register and step sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      out_valid_r  <= 1'b0;
      alu_ctrl_r   <= C_ILL;
      illegal_r    <= 1'b0;
      dz_bypass_r  <= 1'b0;
      step_en_r    <= 1'b0;
      step_first_r <= 1'b0;
      step_last_r  <= 1'b0;
    end else if (flush) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      out_valid_r  <= 1'b0;
      illegal_r    <= 1'b0;
      dz_bypass_r  <= 1'b0;
      step_en_r    <= 1'b0;
      step_first_r <= 1'b0;
      step_last_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            alu_ctrl_r  <= code_s;
            illegal_r   <= (code_s == C_ILL);
            dz_bypass_r <= dz_hit_s;
            if (iter_s) begin
              state_r      <= ST_ITER;
              cnt_r        <= '0;
              out_valid_r  <= 1'b0;
              step_en_r    <= 1'b1;
              step_first_r <= 1'b1;
              step_last_r  <= 1'b0;
            end else begin
              out_valid_r <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        ST_ITER: begin
          step_first_r <= 1'b0;
          if (cnt_r == LAST_CNT) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            out_valid_r <= 1'b1;
            step_en_r   <= 1'b0;
            step_last_r <= 1'b0;
          end else begin
            cnt_r       <= cnt_r + CNT_W'(1);
            step_en_r   <= 1'b1;
            step_last_r <= (cnt_r == PENULT_CNT);
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= '0;
          out_valid_r  <= 1'b0;
          step_en_r    <= 1'b0;
          step_first_r <= 1'b0;
          step_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.alu_ctrl   = alu_ctrl_r;
  assign bus.illegal    = illegal_r;
  assign bus.dz_bypass  = dz_bypass_r;
  assign bus.step_en    = step_en_r;
  assign bus.step_first = step_first_r;
  assign bus.step_last  = step_last_r;
  assign bus.step_cnt   = cnt_r;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized self-checking bench for alu_control_seq against a table-driven decode model.
// Two instances: M extension enabled and disabled, sharing one stimulus stream.
module tb_alu_control_seq;
  localparam int XLEN = 32;
  localparam logic [4:0] ADD = 5'h02, SUB = 5'h06, SRL = 5'h05, SRA = 5'h09, ILL = 5'h1f;
  localparam logic [4:0] BASE_TAB [8] = '{5'h02, 5'h04, 5'h07, 5'h08, 5'h03, 5'h05, 5'h01, 5'h00};

  logic clk = 1'b0;
  logic rst_n, flush;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_control_seq_if #(.XLEN(XLEN)) bus0 ();
  alu_control_seq_if #(.XLEN(XLEN)) bus1 ();

  alu_control_seq #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
  alu_control_seq #(.XLEN(XLEN), .MULDIV_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));

  // Reference decode from the instruction-set rules.
  function automatic logic [4:0] ref_code(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f75, input logic f70, input bit md_en);
    bit rtype;
    if (op == 2'd0) return ADD;
    if (op == 2'd1) return SUB;
    rtype = (op == 2'd2);
    if (rtype && f70) return (f75 || !md_en) ? ILL : (5'h10 + 5'(f3));
    if (f3 == 3'd0) return (rtype && f75) ? SUB : ADD;
    if (f3 == 3'd5) return f75 ? SRA : SRL;
    if (rtype && f75) return ILL;
    return BASE_TAB[f3];
  endfunction

  function automatic bit is_div(input logic [4:0] code);
    return (code >= 5'h14) && (code <= 5'h17);
  endfunction

  function automatic bit is_iter(input logic [4:0] code, input logic dz);
    return (code >= 5'h10) && (code <= 5'h17) && !(dz && is_div(code));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [4:0] ac,
                           input logic il, input logic dz, input logic [4:0] ecode, input logic edz);
    chk({tag, " out_valid"}, 32'(ov), 32'd1);
    chk({tag, " alu_ctrl"}, 32'(ac), 32'(ecode));
    chk({tag, " illegal"}, 32'(il), 32'(ecode == ILL));
    chk({tag, " dz_bypass"}, 32'(dz), 32'(edz));
  endtask

  // Packed op: {alu_op[1:0], funct3[2:0], funct7_5, funct7_0, div_zero}
  task automatic drive(input logic v, input logic [7:0] e);
    bus0.in_valid = v; bus1.in_valid = v;
    bus0.alu_op = e[7:6]; bus1.alu_op = e[7:6];
    bus0.funct3 = e[5:3]; bus1.funct3 = e[5:3];
    bus0.funct7_5 = e[2]; bus1.funct7_5 = e[2];
    bus0.funct7_0 = e[1]; bus1.funct7_0 = e[1];
    bus0.div_zero = e[0]; bus1.div_zero = e[0];
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r; bus1.out_ready = r;
  endtask

  // Back-to-back single-cycle ops on one instance with out_ready held high.
  task automatic run_stream(input bit sel, input bit md_en, input logic [7:0] ops[$]);
    logic [7:0] e;
    logic [4:0] c;
    set_ready(1'b1);
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = ops[i-1];
        c = ref_code(e[7:6], e[5:3], e[2], e[1], md_en);
        if (sel) check_out("stream1", bus1.out_valid, bus1.alu_ctrl, bus1.illegal, bus1.dz_bypass, c, e[0] && is_div(c));
        else     check_out("stream0", bus0.out_valid, bus0.alu_ctrl, bus0.illegal, bus0.dz_bypass, c, e[0] && is_div(c));
      end
      if (i < ops.size()) begin
        drive(1'b1, ops[i]);
        chk("stream in_ready", 32'(sel ? bus1.in_ready : bus0.in_ready), 32'd1);
      end else begin
        drive(1'b0, 8'h00);
      end
    end
    @(negedge clk);
    chk("stream drained", 32'(sel ? bus1.out_valid : bus0.out_valid), 32'd0);
  endtask

  // Iterative M op on dut0 with full step-timing, backpressure and release checks.
  task automatic run_iter(input logic [2:0] f3);
    logic [4:0] c;
    c = ref_code(2'b10, f3, 1'b0, 1'b1, 1'b1);
    set_ready(1'b0);
    @(negedge clk);
    drive(1'b1, {2'b10, f3, 1'b0, 1'b1, 1'b0});
    chk("iter accept in_ready", 32'(bus0.in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00);
    for (int cyc = 1; cyc <= XLEN + 1; cyc++) begin
      if (cyc > 1) @(negedge clk);
      chk("iter step_en", 32'(bus0.step_en), 32'(cyc <= XLEN));
      chk("iter step_first", 32'(bus0.step_first), 32'(cyc == 1));
      chk("iter step_last", 32'(bus0.step_last), 32'(cyc == XLEN));
      chk("iter in_ready", 32'(bus0.in_ready), 32'd0);
      chk("iter out_valid", 32'(bus0.out_valid), 32'(cyc == XLEN + 1));
      if (cyc <= XLEN) chk("iter step_cnt", 32'(bus0.step_cnt), 32'(cyc - 1));
    end
    check_out("iter result", bus0.out_valid, bus0.alu_ctrl, bus0.illegal, bus0.dz_bypass, c, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_out("hold", bus0.out_valid, bus0.alu_ctrl, bus0.illegal, bus0.dz_bypass, c, 1'b0);
      chk("hold in_ready", 32'(bus0.in_ready), 32'd0);
    end
    @(negedge clk);
    set_ready(1'b1);
    drive(1'b1, {2'b00, 3'($urandom), 3'b000});
    #1;
    chk("release in_ready", 32'(bus0.in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00);
    check_out("release next", bus0.out_valid, bus0.alu_ctrl, bus0.illegal, bus0.dz_bypass, ADD, 1'b0);
    @(negedge clk);
    chk("release drained", 32'(bus0.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;

    rst_n = 1'b0;
    flush = 1'b0;
    set_ready(1'b0);
    drive(1'b0, 8'h00);

    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom), 8'($urandom));
      set_ready(1'($urandom));
      chk("rst out_valid", 32'(bus0.out_valid), 32'd0);
      chk("rst alu_ctrl", 32'(bus0.alu_ctrl), 32'h1f);
      chk("rst step_en", 32'(bus0.step_en), 32'd0);
      chk("rst step_cnt", 32'(bus0.step_cnt), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 8'h00);
    set_ready(1'b1);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", 32'(bus0.in_ready), 32'd1);

    // Exhaustive plus random single-cycle decode sweep on dut0.
    for (int c = 0; c < 128; c++) begin
      e = {7'(c), 1'($urandom)};
      if (!is_iter(ref_code(e[7:6], e[5:3], e[2], e[1], 1'b1), e[0])) q.push_back(e);
    end
    for (int i = 0; i < 100; i++) begin
      e = 8'($urandom);
      if (!is_iter(ref_code(e[7:6], e[5:3], e[2], e[1], 1'b1), e[0])) q.push_back(e);
    end
    run_stream(1'b0, 1'b1, q);

    run_iter(3'b000);
    for (int i = 0; i < 3; i++) run_iter(3'($urandom));

    // DIVU with zero divisor bypasses iteration.
    @(negedge clk);
    drive(1'b1, {2'b10, 3'b101, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    drive(1'b0, 8'h00);
    check_out("divu dz", bus0.out_valid, bus0.alu_ctrl, bus0.illegal, bus0.dz_bypass, 5'h15, 1'b1);
    chk("divu dz step_en", 32'(bus0.step_en), 32'd0);
    @(negedge clk);
    chk("divu dz after step_en", 32'(bus0.step_en), 32'd0);

    // Flush REM at step_cnt 10 with a competing in_valid.
    @(negedge clk);
    drive(1'b1, {2'b10, 3'b110, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (10) @(negedge clk);
    chk("flush pre step_cnt", 32'(bus0.step_cnt), 32'd10);
    flush = 1'b1;
    drive(1'b1, 8'h00);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 8'h00);
    chk("flush in_ready", 32'(bus0.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("flush out_valid", 32'(bus0.out_valid), 32'd0);
      chk("flush step_en", 32'(bus0.step_en), 32'd0);
      chk("flush step_cnt", 32'(bus0.step_cnt), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset at step_cnt 20.
    drive(1'b1, {2'b10, 3'b100, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (20) @(negedge clk);
    chk("mid rst pre step_cnt", 32'(bus0.step_cnt), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("mid rst step_en", 32'(bus0.step_en), 32'd0);
    chk("mid rst step_cnt", 32'(bus0.step_cnt), 32'd0);
    chk("mid rst alu_ctrl", 32'(bus0.alu_ctrl), 32'h1f);
    chk("mid rst step_first", 32'(bus0.step_first), 32'd0);
    chk("mid rst out_valid", 32'(bus0.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid rst in_ready", 32'(bus0.in_ready), 32'd1);

    // M extension disabled: every M encoding is single-cycle ILLEGAL.
    q.delete();
    for (int f = 0; f < 16; f++) q.push_back({2'b10, 3'(f >> 1), 1'b0, 1'b1, 1'(f)});
    for (int i = 0; i < 60; i++) q.push_back(8'($urandom));
    run_stream(1'b1, 1'b0, q);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
